// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: filters the pins, deframes bytes and folds F0/E0 prefixes into held key events.
// Latency: outputs update the clk after the strobe that samples the stop bit; timeout error the clk after the limit is hit.
// Backpressure: none; valid and frame_err are single-cycle pulses and the held outputs are overwritten by the next key.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       make,
    output logic       extended,
    output logic       valid,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Synchronizers idle high so a quiet bus does not look like a falling edge out of reset.
    logic clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_data;
            dat_sync_q <= dat_meta_q;
        end
    end

    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          strobe;

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        strobe     = 1'b0;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FILT_MAX) begin
                filt_d = ~filt_q;
                strobe = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          brk_pend_q, brk_pend_d;
    logic          ext_pend_q, ext_pend_d;
    logic [7:0]    keycode_q, keycode_d;
    logic          make_q, make_d;
    logic          ext_q, ext_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          byte_ok;

    assign byte_ok = dat_sync_q & (^{shift_q, par_q});

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        to_cnt_d   = '0;
        brk_pend_d = brk_pend_q;
        ext_pend_d = ext_pend_q;
        keycode_d  = keycode_q;
        make_d     = make_q;
        ext_d      = ext_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        if (state_q != IDLE && !strobe) begin
            if (to_cnt_q == TO_MAX) begin
                err_d      = 1'b1;
                brk_pend_d = 1'b0;
                ext_pend_d = 1'b0;
                state_d    = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        if (strobe) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat_sync_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dat_sync_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!byte_ok) begin
                        err_d      = 1'b1;
                        brk_pend_d = 1'b0;
                        ext_pend_d = 1'b0;
                    end else begin
                        unique case (shift_q)
                            8'hF0: brk_pend_d = 1'b1;
                            8'hE0: ext_pend_d = 1'b1;
                            // Controller responses and overrun codes carry no key information.
                            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: ;
                            default: begin
                                keycode_d  = shift_q;
                                make_d     = ~brk_pend_q;
                                ext_d      = ext_pend_q;
                                valid_d    = 1'b1;
                                brk_pend_d = 1'b0;
                                ext_pend_d = 1'b0;
                            end
                        endcase
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            keycode_q  <= 8'h00;
            make_q     <= 1'b0;
            ext_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            brk_pend_q <= brk_pend_d;
            ext_pend_q <= ext_pend_d;
            keycode_q  <= keycode_d;
            make_q     <= make_d;
            ext_q      <= ext_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign keycode   = keycode_q;
    assign make      = make_q;
    assign extended  = ext_q;
    assign valid     = valid_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: frames are bit-banged and expected events queued for an output monitor.
module tb_ps2_keyboard_rx;

    localparam int FL = 8;
    localparam int TO = 200;
    localparam int HALF = 20;

    logic       clk;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       make;
    logic       extended;
    logic       valid;
    logic       frame_err;

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keycode   (keycode),
        .make      (make),
        .extended  (extended),
        .valid     (valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] kc;
        logic       mk;
        logic       ex;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   last_fall_cyc = 0;
    int   last_err_cyc = -1;
    logic [7:0] held_kc = 8'h00;
    logic       held_mk = 1'b0;
    logic       held_ex = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_key(input logic [7:0] kc, input logic mk, input logic ex);
        exp_t e;
        e.is_err = 1'b0; e.kc = kc; e.mk = mk; e.ex = ex;
        exp_q.push_back(e);
        held_kc = kc; held_mk = mk; held_ex = ex;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1; e.kc = held_kc; e.mk = held_mk; e.ex = held_ex;
        exp_q.push_back(e);
    endtask

    // One bit cell: data set while clock high, optional short low glitch, then a full low phase.
    task automatic send_bit(input logic b, input bit glitch);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF / 2) @(negedge clk);
        if (glitch) begin
            ps2_clk = 1'b0;
            repeat (FL - 1) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF / 2) @(negedge clk);
        end
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF / 2) @(negedge clk);
    endtask

    // nbits limits how many of the 11 frame bits go out, to build truncated frames.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input int glitch_at);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(fr[i], i == glitch_at);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11, -1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3 * TO && exp_q.size() != 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    task automatic check_held(input string tag, input logic [7:0] kc, input logic mk, input logic ex);
        check({tag, "_kc"}, keycode, kc);
        check({tag, "_mk"}, make, mk);
        check({tag, "_ex"}, extended, ex);
    endtask

    initial begin
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;

        fork
            forever begin
                @(posedge clk);
                #1;
                if (reset_n && (valid || frame_err)) begin
                    exp_t e;
                    check("pulse_exclusive", valid & frame_err, 0);
                    check("pulse_expected", exp_q.size() > 0, 1);
                    if (frame_err) last_err_cyc = cyc;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("pulse_kind_err", frame_err, e.is_err);
                        check("out_keycode", keycode, e.kc);
                        check("out_make", make, e.mk);
                        check("out_extended", extended, e.ex);
                    end
                end
            end
        join_none

        repeat (4) @(negedge clk);
        check("rst_keycode", keycode, 8'h00);
        check("rst_make", make, 0);
        check("rst_extended", extended, 0);
        check("rst_valid", valid, 0);
        check("rst_frame_err", frame_err, 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        push_key(8'h75, 1, 0);
        send(8'h75);
        wait_drain("drain_make75");
        repeat (50) @(negedge clk);
        check_held("held75", 8'h75, 1, 0);

        send(8'hF0);
        push_key(8'h75, 0, 0);
        send(8'h75);
        wait_drain("drain_break75");

        send(8'hE0);
        push_key(8'h6B, 1, 1);
        send(8'h6B);
        send(8'hE0);
        send(8'hF0);
        push_key(8'h6B, 0, 1);
        send(8'h6B);
        wait_drain("drain_ext6b");

        send(8'hF0);
        push_err();
        send_frame(8'h1B, 1'b1, 11, -1);
        wait_drain("drain_parity_err");
        check_held("held_after_err", 8'h6B, 0, 1);
        push_key(8'h1B, 1, 0);
        send(8'h1B);
        wait_drain("drain_after_err");

        send(8'hF0);
        push_err();
        send_frame(8'h00, 1'b0, 5, -1);
        wait_drain("drain_timeout");
        check("timeout_latency", last_err_cyc - last_fall_cyc, FL + 2 + TO);
        push_key(8'h74, 1, 0);
        send(8'h74);
        wait_drain("drain_after_timeout");

        send(8'hAA);
        send(8'hFA);
        push_key(8'h74, 1, 0);
        send(8'h74);
        wait_drain("drain_repeat74");

        push_key(8'h29, 1, 0);
        send_frame(8'h29, 1'b0, 11, 4);
        wait_drain("drain_glitch");

        send_frame(8'h55, 1'b0, 6, -1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_keycode", keycode, 8'h00);
        check("midrst_make", make, 0);
        check("midrst_extended", extended, 0);
        check("midrst_valid", valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        held_kc = 8'h00; held_mk = 1'b0; held_ex = 1'b0;
        repeat (5) @(negedge clk);
        push_key(8'h72, 1, 0);
        send(8'h72);
        wait_drain("drain_after_reset");
        check_held("final", 8'h72, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Receives PS/2 device-to-host frames from the keyboard and assembles scan-code sequences, including the F0 (break) and E0 (extended) prefixes.
- Presents a held keycode with a level make flag that feeds the keycode decoder directly.
- Sits between the board's PS/2 pins and the keycode decoder in the etch-a-sketch input path.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized ps2_clk samples required before the filtered clock level changes; minimum 2.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered ps2_clk falling edge after which an in-progress frame is aborted.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- ps2_clk  input  1  raw PS/2 clock pin (asynchronous)
- ps2_data  input  1  raw PS/2 data pin (asynchronous)
- keycode  output  8  last complete scan code, held until the next one
- make  output  1  1 = last code was a press, 0 = release; held
- extended  output  1  1 = last code was E0-prefixed; held
- valid  output  1  one-cycle pulse when keycode/make/extended update
- frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n). While reset_n=0: keycode=0x00, make=0, extended=0, valid=0, frame_err=0, state=IDLE, bit counter, timeout counter and prefix flags cleared, filtered clock=1. Deasserting reset mid-frame leaves the receiver in IDLE. It resynchronizes on the next start bit or via timeout.
- Input conditioning:
  - ps2_clk and ps2_data each pass through 2 flops.
  - Filtered clock toggles only after FILTER_LEN consecutive synchronized samples at the new level.
  - strobe = filtered clock 1->0. Data is sampled (synchronized) in the strobe cycle.
- FSM:
  - IDLE: on strobe with data=0 -> DATA, bit_cnt=0. On strobe with data=1, stay in IDLE with no error.
  - DATA: on each strobe, shift the bit in LSB-first. After the 8th bit -> PARITY.
  - PARITY: on strobe, capture the parity bit -> STOP.
  - STOP: on strobe, the byte is good iff stop=1 and XOR(data[7:0], parity)=1 (odd parity). Good byte -> byte handling. Bad byte -> frame_err pulse, both prefix flags cleared. Either way -> IDLE.
- Timeout:
  - In DATA/PARITY/STOP, the counter clears on every strobe and otherwise increments.
  - When it reaches TIMEOUT_CYCLES-1: frame_err pulse, prefix flags cleared, -> IDLE.
  - Counter is held at 0 in IDLE.
- Byte handling (good byte):
  - 0xF0: set break_pending; no output change.
  - 0xE0: set ext_pending; no output change.
  - 0xAA, 0xFA, 0xEE, 0xFE, 0xFC, 0x00, 0xFF: ignored; outputs and pending flags unchanged.
  - Any other byte: keycode=byte, make=~break_pending, extended=ext_pending, valid=1 for one cycle, both pending flags cleared.
  - Repeated prefixes are idempotent.
- Latency:
  - keycode/make/extended/valid/frame_err are registered and change on the clk edge following the strobe that samples the stop bit (visible in cycle T+1, where T is the strobe cycle).
  - Timeout frame_err is visible the cycle after the counter hits its limit.
- valid and frame_err are never asserted in the same cycle. Each is exactly 1 cycle wide.
- Typematic repeat: repeated make codes produce repeated valid pulses with identical outputs.

Test Plan:
- Frame 0x75 (parity bit 0, stop 1), clk period >> FILTER_LEN -> exactly one valid pulse; keycode=0x75, make=1, extended=0; outputs held afterwards.
- Frames 0xF0 then 0x75 -> no valid after 0xF0; one valid after 0x75 with keycode=0x75, make=0, extended=0.
- Frames 0xE0 0x6B, then 0xE0 0xF0 0x6B -> first: keycode=0x6B, make=1, extended=1. Second: make=0, extended=1. Exactly two valid pulses total.
- Frame 0x1B with parity bit 0 (correct is 1) -> one frame_err pulse, no valid, outputs unchanged. Following F0 prefix state is cleared, so a subsequent 0x1B gives make=1.
- Start bit plus 4 data bits, then clock held high -> frame_err exactly TIMEOUT_CYCLES cycles after the last strobe. A subsequent clean 0x74 frame gives keycode=0x74, make=1.
- ps2_clk low glitch of FILTER_LEN-1 cycles mid-frame -> no bit sampled, byte still decoded correctly. reset_n pulsed low mid-frame -> all outputs 0 immediately; next full 0x72 frame decodes correctly.
